// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-register definitions: exception codes and the skid-stage occupancy encoding.
package pipe_skid_stage_pkg;

   localparam int unsigned EXC_W_DEFAULT = 5;
   localparam logic [EXC_W_DEFAULT-1:0] EC_NONE = '0;

   // Encoding matches the occupancy count so it can drive the port directly.
   typedef enum logic [1:0] {
      OccEmpty = 2'd0,
      OccOne   = 2'd1,
      OccFull  = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline register with a skid buffer, so in_ready is fully registered.
// Empty entries present a NOP bubble (all-zero payload, EC_NONE).
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned EXC_W  = EXC_W_DEFAULT,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic [ADDR_W-1:0] in_epc,
   input  logic [ADDR_W-1:0] in_badvaddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exc,
   output logic [ADDR_W-1:0] out_epc,
   output logic [ADDR_W-1:0] out_badvaddr,
   output logic [1:0]        occupancy
);

   localparam int unsigned EntryW = DATA_W + EXC_W + 2 * ADDR_W;
   localparam logic [EntryW-1:0] BubbleEntry =
      {{DATA_W{1'b0}}, EXC_W'(EC_NONE), {(2 * ADDR_W){1'b0}}};

   logic [EntryW-1:0] in_entry;
   logic [EntryW-1:0] main_d, main_q;
   logic [EntryW-1:0] skid_d, skid_q;
   logic              main_valid_d, main_valid_q;
   logic              skid_valid_d, skid_valid_q;
   logic              in_fire, out_fire;
   occ_e              state;

   assign in_entry = {in_data, in_exc, in_epc, in_badvaddr};

   // State is derived from the two valid bits; skid is only ever valid while main is.
   always_comb begin
      state = OccEmpty;
      case ({skid_valid_q, main_valid_q})
         2'b00:   state = OccEmpty;
         2'b01:   state = OccOne;
         2'b11:   state = OccFull;
         default: state = OccEmpty;
      endcase
   end

   assign in_ready  = (state != OccFull);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid_q & out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;

      if (flush) begin
         main_d       = BubbleEntry;
         skid_d       = BubbleEntry;
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case (state)
            OccEmpty: begin
               if (in_fire) begin
                  main_d       = in_entry;
                  main_valid_d = 1'b1;
               end
            end
            OccOne: begin
               if (in_fire && out_fire) begin
                  main_d = in_entry;
               end else if (in_fire) begin
                  skid_d       = in_entry;
                  skid_valid_d = 1'b1;
               end else if (out_fire) begin
                  main_d       = BubbleEntry;
                  main_valid_d = 1'b0;
               end
            end
            OccFull: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  main_d       = skid_q;
                  skid_d       = BubbleEntry;
                  skid_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         main_q       <= BubbleEntry;
         skid_q       <= BubbleEntry;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid = main_valid_q;
   assign {out_data, out_exc, out_epc, out_badvaddr} = main_q;
   assign occupancy = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model checked every cycle plus directed
// scenarios with literal expectations.
module tb_pipe_skid_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [4:0]   in_exc;
   logic [31:0]  in_epc;
   logic [31:0]  in_badvaddr;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [4:0]   out_exc;
   logic [31:0]  out_epc;
   logic [31:0]  out_badvaddr;
   logic [1:0]   occupancy;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_skid_stage dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_exc       (in_exc),
      .in_epc       (in_epc),
      .in_badvaddr  (in_badvaddr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_exc      (out_exc),
      .out_epc      (out_epc),
      .out_badvaddr (out_badvaddr),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered queue of at most two beats.
   typedef struct packed {
      logic [127:0] d;
      logic [4:0]   e;
      logic [31:0]  pc;
      logic [31:0]  bv;
   } beat_t;

   beat_t q[$];
   bit    started = 1'b0;
   bit    acc_in, acc_out;
   beat_t exp_beat;

   always @(posedge clk) begin
      started = 1'b1;
      if (!rst || flush) begin
         q.delete();
      end else begin
         acc_out = (q.size() > 0) && out_ready;
         acc_in  = in_valid && (q.size() < 2);
         if (acc_out) void'(q.pop_front());
         if (acc_in) q.push_back('{d: in_data, e: in_exc, pc: in_epc, bv: in_badvaddr});
      end
   end

   always @(negedge clk) begin
      if (started) begin
         exp_beat = (q.size() > 0) ? q[0] : '0;
         check("m_out_valid", out_valid, q.size() > 0);
         check("m_in_ready", in_ready, q.size() < 2);
         check("m_occupancy", occupancy, q.size());
         check("m_out_data", out_data, exp_beat.d);
         check("m_out_exc", out_exc, exp_beat.e);
         check("m_out_epc", out_epc, exp_beat.pc);
         check("m_out_badvaddr", out_badvaddr, exp_beat.bv);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_exc = '0; in_epc = '0; in_badvaddr = '0;

      // Reset held for two cycles.
      step(); step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_exc", out_exc, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occupancy", occupancy, 0);
      rst = 1'b1;

      // Streaming with no backpressure: one-cycle latency, occupancy stays 1.
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 128'(i);
         step();
         check("stream_data", out_data, 128'(i));
         check("stream_occ", occupancy, 1);
      end
      in_valid = 1'b0;
      step();
      check("stream_bubble_valid", out_valid, 0);
      check("stream_bubble_data", out_data, 0);

      // Backpressure fills the skid; order must be preserved.
      in_valid = 1'b1; in_data = 128'hA; out_ready = 1'b1;
      step();
      check("bp_a_head", out_data, 128'hA);
      out_ready = 1'b0; in_data = 128'hB;
      step();
      check("bp_full_occ", occupancy, 2);
      check("bp_full_ready", in_ready, 0);
      check("bp_full_head", out_data, 128'hA);
      check("model_full_size", q.size(), 2);
      in_data = 128'hC;
      out_ready = 1'b1;
      #1;
      check("bp_ready_not_comb", in_ready, 0);
      out_ready = 1'b0;
      step();
      check("bp_c_refused_occ", occupancy, 2);
      check("bp_c_refused_head", out_data, 128'hA);
      out_ready = 1'b1;
      step();
      check("bp_b_head", out_data, 128'hB);
      check("bp_b_occ", occupancy, 1);
      step();
      check("bp_c_head", out_data, 128'hC);
      in_valid = 1'b0;
      step();
      check("bp_drained_occ", occupancy, 0);

      // Flush while FULL drops everything including the beat offered that cycle.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h1;
      step();
      in_data = 128'h2;
      step();
      in_data = 128'hD; flush = 1'b1;
      step();
      check("flush_valid", out_valid, 0);
      check("flush_data", out_data, 0);
      check("flush_occ", occupancy, 0);
      check("flush_ready", in_ready, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      check("flush_no_d", out_valid, 0);

      // Exception side fields travel with the payload and clear on drain.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h55;
      in_exc = 5'd3; in_epc = 32'h8000_0180; in_badvaddr = 32'h1234;
      step();
      check("exc_code", out_exc, 3);
      check("exc_epc", out_epc, 32'h8000_0180);
      check("exc_badvaddr", out_badvaddr, 32'h1234);
      check("exc_data", out_data, 128'h55);
      in_valid = 1'b0; in_exc = '0; in_epc = '0; in_badvaddr = '0; out_ready = 1'b1;
      step();
      check("exc_clear_code", out_exc, 0);
      check("exc_clear_epc", out_epc, 0);
      check("exc_clear_badvaddr", out_badvaddr, 0);

      // Reset mid-operation wins over flush and discards held beats.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h7;
      step(); step();
      rst = 1'b0; flush = 1'b1;
      step();
      check("midrst_occ", occupancy, 0);
      check("midrst_data", out_data, 0);
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      step();

      // Random traffic; the per-cycle model comparison does the checking.
      for (int c = 0; c < 10000; c++) begin
         in_valid    = 1'($urandom_range(0, 1));
         out_ready   = 1'($urandom_range(0, 1));
         flush       = ($urandom_range(0, 63) == 0);
         in_data     = {$urandom, $urandom, $urandom, $urandom};
         in_exc      = 5'($urandom);
         in_epc      = $urandom;
         in_badvaddr = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
